// File: rtl/updown_counter_n.sv
// updown_counter_n: synchronous up/down counter with modulus, load, enable and terminal count.
// Define UPDOWN_CNT_SATURATE_EN to hold at the range ends instead of wrapping.
module updown_counter_n #(
  parameter int WIDTH = 4,
  parameter int MOD   = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);
  logic [WIDTH-1:0] cnt_q, cnt_d, inc, dec, ld;
  logic             at_max, at_min;
  assign at_max = cnt_q == MAX;
  assign at_min = cnt_q == '0;
  assign ld     = (load_val > MAX) ? MAX : load_val;
`ifdef UPDOWN_CNT_SATURATE_EN
  assign inc = at_max ? MAX : cnt_q + WIDTH'(1);
  assign dec = at_min ? '0 : cnt_q - WIDTH'(1);
`else
  assign inc = at_max ? '0 : cnt_q + WIDTH'(1);
  assign dec = at_min ? MAX : cnt_q - WIDTH'(1);
`endif
  always_comb cnt_d = load ? ld : en ? (up_dn ? inc : dec) : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  assign q  = cnt_q;
  assign tc = en & ~load & (up_dn ? at_max : at_min);
endmodule

// File: tb/tb_updown_counter_n.sv
// tb_updown_counter_n: directed bench for a MOD-10 and a MOD-4 counter against a behavioural model.
module tb_updown_counter_n;
  logic clk = 0, rst = 0, en = 0, up_dn = 1, load = 0;
  logic [3:0] load_val = 0;
  logic [3:0] q;
  logic [1:0] q2;
  logic tc, tc2, chk = 0;
  int vectors = 0, miscompares = 0;
  int m1 = 0, m2 = 0;

  updown_counter_n #(.WIDTH(4), .MOD(10)) u1 (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val), .q(q), .tc(tc));
  updown_counter_n #(.WIDTH(2), .MOD(4)) u2 (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val[1:0]), .q(q2), .tc(tc2));

  always #5 clk = ~clk;

  function automatic int nxt(int m, int mod, bit e, bit u, bit l, int lv);
    if (l) return (lv >= mod) ? mod - 1 : lv;
    if (!e) return m;
`ifdef UPDOWN_CNT_SATURATE_EN
    if (u) return (m == mod - 1) ? m : m + 1;
    return (m == 0) ? 0 : m - 1;
`else
    if (u) return (m + 1) % mod;
    return (m + mod - 1) % mod;
`endif
  endfunction

  function automatic int tcx(int m, int mod, bit e, bit u, bit l);
    return int'(e && !l && (u ? m == mod - 1 : m == 0));
  endfunction

  task automatic check(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst)
    if (!rst) begin
      m1 <= 0;
      m2 <= 0;
    end else begin
      m1 <= nxt(m1, 10, en, up_dn, load, int'(load_val));
      m2 <= nxt(m2, 4, en, up_dn, load, int'(load_val[1:0]));
    end

  always @(negedge clk)
    if (chk) begin
      check("model_q", int'(q), m1);
      check("model_tc", int'(tc), tcx(m1, 10, en, up_dn, load));
      check("model_q2", int'(q2), m2);
      check("model_tc2", int'(tc2), tcx(m2, 4, en, up_dn, load));
    end

  task automatic set(bit e, bit u, bit l, int lv);
    en = e; up_dn = u; load = l; load_val = 4'(lv);
  endtask

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    set(0, 1, 0, 0);
    edges(2);
    check("reset_q", int'(q), 0);
    rst = 1;
    chk = 1;
    set(1, 1, 0, 0);
    edges(7);
    check("run_to_7", int'(q), 7);
    #2 rst = 0;
    #1 check("async_reset_q", int'(q), 0);
    rst = 1;
    edges(1);
    check("post_reset_q", int'(q), 1);
`ifndef UPDOWN_CNT_SATURATE_EN
    set(1, 1, 1, 0);
    edges(1);
    set(1, 1, 0, 0);
    edges(9);
    check("up_at_9_q", int'(q), 9);
    check("up_at_9_tc", int'(tc), 1);
    edges(1);
    check("up_wrap_q", int'(q), 0);
    check("up_at_0_tc", int'(tc), 0);
    edges(20);
    check("two_periods_q", int'(q), 0);
    set(0, 0, 1, 2);
    edges(1);
    set(1, 0, 0, 0);
    check("down_start_q", int'(q), 2);
    edges(2);
    check("down_at_0_q", int'(q), 0);
    check("down_at_0_tc", int'(tc), 1);
    edges(1);
    check("down_wrap_q", int'(q), 9);
    check("down_at_9_tc", int'(tc), 0);
    edges(1);
    check("down_8_q", int'(q), 8);
`endif
    set(1, 1, 1, 5);
    edges(1);
    check("load5_q", int'(q), 5);
    check("load_tc", int'(tc), 0);
    set(1, 1, 1, 13);
    edges(1);
    check("clamp_q", int'(q), 9);
    check("clamp_tc", int'(tc), 0);
    set(1, 1, 1, 4);
    edges(1);
    set(0, 1, 0, 0);
    edges(5);
    check("hold_q", int'(q), 4);
    check("hold_tc", int'(tc), 0);
    for (int i = 0; i < 4; i++) begin
      set(1, (i % 2) == 0, 0, 0);
      edges(1);
      check("toggle_q", int'(q), (i % 2 == 0) ? 5 : 4);
    end
    set(1, 1, 1, 3);
    edges(1);
    check("q2_load3", int'(q2), 3);
    set(1, 1, 0, 0);
    edges(1);
`ifndef UPDOWN_CNT_SATURATE_EN
    check("q2_rollover", int'(q2), 0);
`else
    check("q2_sat_hold", int'(q2), 3);
    set(1, 1, 1, 8);
    edges(1);
    set(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      edges(1);
      check("sat_up_q", int'(q), 9);
      check("sat_up_tc", int'(tc), 1);
    end
    set(1, 0, 1, 1);
    edges(1);
    set(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      edges(1);
      check("sat_dn_q", int'(q), 0);
      check("sat_dn_tc", int'(tc), 1);
    end
`endif
    edges(1);
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
